mem_responder: RTL and testbench
================================

# mem_responder

Dual-read, single-write word memory that services the CPU's instruction-fetch port and data port with a fixed two-cycle read latency, matching the CPU's two memory stages. An image-load phase after reset streams the program into the array before the CPU is released. Write-first bypass keeps same-cycle store/load pairs coherent.

## Interface
- DW, 16: data word width
- AW, 15: word-address width; the CPU drives byte address [15:1]
- DEPTH, 32768: implemented words; addresses >= DEPTH are out of range
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- raddr0  in  AW  fetch-port word address, sampled every RUN cycle
- rdata0  out  DW  fetch-port read data
- rvalid0  out  1  rdata0 holds a valid response
- raddr1  in  AW  data-port word address, sampled every RUN cycle
- rdata1  out  DW  data-port read data
- rvalid1  out  1  rdata1 holds a valid response
- wen  in  1  write strobe, honoured only in RUN
- waddr  in  AW  write word address
- wdata  in  DW  write data
- ld_valid  in  1  load word present
- ld_data  in  DW  load word
- ld_done  in  1  end of image; move to RUN
- ready  out  1  high in RUN; the CPU is held while this is low
- ld_count  out  AW+1  number of words loaded so far
- ld_overflow  out  1  sticky: a load word was dropped because the array was full

## Operation
- The FSM has two states, LOAD and RUN. Reset enters LOAD.
- In LOAD:
  - ld_valid writes ld_data to address ld_count, then ld_count increments.
  - When ld_count == DEPTH, load words are dropped and ld_overflow is set. ld_count saturates at DEPTH.
  - When ld_done is sampled high, the state moves to RUN on that edge. If ld_valid is high in the same cycle, that word is written first.
  - CPU wen is ignored, and no reads are launched.
- In RUN:
  - Each read port launches one read per cycle. There is no read enable.
  - The load inputs are ignored. ld_count and ld_overflow hold.
- A read sampled in cycle t returns the array contents including any write committed in cycle t (write-first). A write in cycle t+1 is not visible to it.
- Bypass: if wen is high and waddr == raddrN in the sampling cycle, the response is wdata.
- Out-of-range reads return 16'h0000 with rvalidN still high. Out-of-range writes are dropped.
- Both read ports may hit the same address at once; both return identical data.
- Reset mid-operation:
  - The state returns to LOAD and the pipelines clear.
  - ld_count returns to 0 and ld_overflow clears.
  - Array contents are retained; reset does not clear the RAM.

## Timing
- Read latency: an address sampled at the edge ending cycle t gives rdataN/rvalidN valid throughout cycle t+2.
- Throughput is one read per port per cycle, plus one write per cycle.
- rvalidN goes high in the cycle the FSM has been in RUN for 2 cycles, i.e. 2 cycles after ready rises. It stays high until reset.
- ready rises in the cycle after the edge that sampled ld_done.
- Write commit: the array updates at the edge that samples wen. Any read sampled after that edge sees the new data.
- Reset values (asserted asynchronously):
  - rdata0 = rdata1 = 0, rvalid0 = rvalid1 = 0
  - ready = 0, ld_count = 0, ld_overflow = 0
- Address comparisons use the full AW bits. The range check is addr < DEPTH, computed at AW+1 bits.

## Structure
- Shared package mem_pkg holds:
  - the state enum {ST_LOAD, ST_RUN}
  - DW/AW defaults
  - the out-of-range read value 16'h0000
- Sub-module mem_read_pipe, instantiated once per read port:
  - stage 1 registers the address, the bypass hit and the bypass data, together with valid
  - stage 2 registers the output data and rvalid
- The top level contains the array, the write mux (load vs CPU), the FSM and the load counter.

## Test plan
- Load 4 words (1111, 2222, 3333, 4444), then pulse ld_done. Require:
  - ready high 1 cycle after ld_done
  - ld_count == 4
  - raddr0 = 0..3 issued back-to-back returns 1111..4444 on rdata0 at t+2, with rvalid0 high
- Same-cycle bypass: wen with waddr = 5, wdata = ABCD and raddr1 = 5 in cycle t -> rdata1 == ABCD in cycle t+2.
- Write after read: raddr1 = 6 in cycle t, then a write of 6 := BEEF in cycle t+1. Require:
  - cycle t+2 returns the old value
  - a read of 6 issued in cycle t+2 returns BEEF in cycle t+4
- Overflow: with DEPTH = 8, stream 10 load words -> ld_count == 8, ld_overflow == 1, and addresses 0..7 hold the first 8 words.
- Out of range: with DEPTH = 8, a write of 9 := 1234 is dropped, and a read of 9 returns 0000 with rvalid high.
- Reset mid-RUN: assert rst_n low. Require:
  - rvalid, ready and ld_count are 0 immediately, without waiting for a clock
  - after reload with ld_done only (no words), the earlier contents are still readable

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the
// dual-read, single-write word memory.
package mem_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 15;

    // Data returned for reads outside the implemented array
    localparam logic [DW_DEF-1:0] RD_OOR = 16'h0000;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: two-stage read pipeline for one port.
// Stage 1 captures address and bypass, stage 2 the data.
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 32768
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          launch,
    input  logic [AW-1:0] raddr,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [AW-1:0] addr_q,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          valid_q;
    logic          hit_q;
    logic          inr_q;
    logic [DW-1:0] byp_q;
    logic          inr;

    assign inr = {1'b0, raddr} < DEPTH_W;

    // Stage 1: sample address, range and same-cycle write hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            inr_q   <= 1'b0;
            hit_q   <= 1'b0;
            byp_q   <= '0;
        end else begin
            valid_q <= launch;
            addr_q  <= raddr;
            inr_q   <= inr;
            hit_q   <= wr_en && (waddr == raddr);
            byp_q   <= wdata;
        end
    end

    // Stage 2: select bypass, array or out-of-range value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= valid_q;
            if (!inr_q)
                rdata <= DW'(RD_OOR);
            else if (hit_q)
                rdata <= byp_q;
            else
                rdata <= mem_rdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: image loader plus two read ports and
// one write port over a shared word array.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 32768
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    output logic          rvalid1,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_done,
    output logic          ready,
    output logic [AW:0]   ld_count,
    output logic          ld_overflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q;
    state_t        state_d;
    logic          run;
    logic          ld_room;
    logic          ld_we;
    logic          cpu_we;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] addr_q0;
    logic [AW-1:0] addr_q1;
    logic [DW-1:0] mrd0;
    logic [DW-1:0] mrd1;

    assign run     = (state_q == ST_RUN);
    assign ld_room = ld_count < DEPTH_W;
    assign ld_we   = !run && ld_valid && ld_room;
    assign cpu_we  = run && wen && ({1'b0, waddr} < DEPTH_W);
    assign mem_we  = ld_we || cpu_we;

    assign mem_waddr = run ? waddr : ld_count[AW-1:0];
    assign mem_wdata = run ? wdata : ld_data;

    // Array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr[IW-1:0]] <= mem_wdata;
    end

    // Stage-2 array reads; out-of-range slots are masked
    assign mrd0 = mem[addr_q0[IW-1:0]];
    assign mrd1 = mem[addr_q1[IW-1:0]];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_LOAD;
        else
            state_q <= state_d;
    end

    // FSM next state and ready
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (ld_done)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                ready = 1'b1;
            end
        endcase
    end

    // Load counter with saturation and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count    <= '0;
            ld_overflow <= 1'b0;
        end else if (!run && ld_valid) begin
            if (ld_room)
                ld_count <= ld_count + (AW+1)'(1);
            else
                ld_overflow <= 1'b1;
        end
    end

    mem_read_pipe #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_pipe0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (run),
        .raddr     (raddr0),
        .wr_en     (cpu_we),
        .waddr     (waddr),
        .wdata     (wdata),
        .addr_q    (addr_q0),
        .mem_rdata (mrd0),
        .rdata     (rdata0),
        .rvalid    (rvalid0)
    );

    mem_read_pipe #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_pipe1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (run),
        .raddr     (raddr1),
        .wr_en     (cpu_we),
        .waddr     (waddr),
        .wdata     (wdata),
        .addr_q    (addr_q1),
        .mem_rdata (mrd1),
        .rdata     (rdata1),
        .rvalid    (rvalid1)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors plus randomized
// traffic against a word-array reference model.
module tb_mem_responder;

    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] raddr0, raddr1, waddr;
    logic [DW-1:0] rdata0, rdata1, wdata, ld_data;
    logic          rvalid0, rvalid1, wen, ld_valid, ld_done;
    logic          ready, ld_overflow;
    logic [AW:0]   ld_count;

    always #5 clk = ~clk;

    mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr0(raddr0), .rdata0(rdata0), .rvalid0(rvalid0),
        .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
        .ready(ready), .ld_count(ld_count), .ld_overflow(ld_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: array contents, which words are defined,
    // load progress, and the response due in the next cycle.
    logic [DW-1:0] mem_m [DEPTH];
    bit            known [DEPTH];
    bit            run_m = 0;
    bit            ovf_m = 0;
    int            cnt_m = 0;

    typedef struct {
        bit            v;
        bit            k0;
        logic [DW-1:0] d0;
        bit            k1;
        logic [DW-1:0] d1;
    } resp_t;

    resp_t held  = '{default: 0};
    resp_t shown = '{default: 0};

    typedef struct {
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_read(input logic [AW-1:0] a,
                                       output bit k,
                                       output logic [DW-1:0] d);
        if (a < DEPTH) begin
            k = known[a];
            d = mem_m[a];
        end else begin
            k = 1;
            d = 16'h0000;
        end
    endfunction

    task automatic idle();
        raddr0 = '0; raddr1 = '0;
        wen = 0; waddr = '0; wdata = '0;
        ld_valid = 0; ld_data = '0; ld_done = 0;
    endtask

    // One clock: advance the model with the inputs sampled at the
    // edge, then compare every output shortly after the edge.
    task automatic step();
        resp_t nw;
        @(posedge clk);
        nw = '{default: 0};
        if (run_m) begin
            if (wen && waddr < DEPTH) begin
                mem_m[waddr] = wdata;
                known[waddr] = 1;
            end
            nw.v = 1;
            model_read(raddr0, nw.k0, nw.d0);
            model_read(raddr1, nw.k1, nw.d1);
        end else begin
            if (ld_valid) begin
                if (cnt_m < DEPTH) begin
                    mem_m[cnt_m] = ld_data;
                    known[cnt_m] = 1;
                    cnt_m++;
                end else begin
                    ovf_m = 1;
                end
            end
            if (ld_done) run_m = 1;
        end
        shown = held;
        held  = nw;
        #1;
        chk("ready", ready, run_m);
        chk("ld_count", ld_count, cnt_m);
        chk("ld_overflow", ld_overflow, ovf_m);
        chk("rvalid0", rvalid0, shown.v);
        chk("rvalid1", rvalid1, shown.v);
        if (shown.v && shown.k0) chk("rdata0", rdata0, shown.d0);
        if (shown.v && shown.k1) chk("rdata1", rdata1, shown.d1);
    endtask

    // Asynchronous reset between edges; outputs must drop at once.
    task automatic mid_reset();
        idle();
        #2 rst_n = 0;
        #1;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ld_count", ld_count, 0);
        chk("rst_ld_overflow", ld_overflow, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        run_m = 0; ovf_m = 0; cnt_m = 0;
        held = '{default: 0};
        shown = '{default: 0};
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{15'd0, 15'd0, 1'b0, 15'd0, 16'h0000, 16'h1111, 16'h1111};
        tbl[1]  = '{15'd1, 15'd3, 1'b0, 15'd0, 16'h0000, 16'h2222, 16'h4444};
        tbl[2]  = '{15'd2, 15'd5, 1'b1, 15'd5, 16'hABCD, 16'h3333, 16'hABCD};
        tbl[3]  = '{15'd3, 15'd2, 1'b1, 15'd6, 16'h1357, 16'h4444, 16'h3333};
        tbl[4]  = '{15'd5, 15'd6, 1'b0, 15'd0, 16'h0000, 16'hABCD, 16'h1357};
        tbl[5]  = '{15'd6, 15'd0, 1'b1, 15'd6, 16'hBEEF, 16'hBEEF, 16'h1111};
        tbl[6]  = '{15'd1, 15'd6, 1'b0, 15'd0, 16'h0000, 16'h2222, 16'hBEEF};
        tbl[7]  = '{15'd9, 15'd3, 1'b1, 15'd9, 16'h1234, 16'h0000, 16'h4444};
        tbl[8]  = '{15'd9, 15'd5, 1'b0, 15'd0, 16'h0000, 16'h0000, 16'hABCD};
        tbl[9]  = '{15'd6, 15'd6, 1'b0, 15'd0, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[10] = '{15'd1, 15'd1, 1'b0, 15'd0, 16'h0000, 16'h2222, 16'h2222};

        idle();
        #1 rst_n = 0;
        #1;
        chk("init_rvalid0", rvalid0, 0);
        chk("init_rvalid1", rvalid1, 0);
        chk("init_ready", ready, 0);
        chk("init_ld_count", ld_count, 0);
        chk("init_ld_overflow", ld_overflow, 0);
        chk("init_rdata0", rdata0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;

        for (int i = 0; i < 4; i++) begin
            ld_valid = 1;
            ld_data = DW'(16'h1111 * (i + 1));
            step();
        end
        idle();
        chk("ready_before_done", ready, 0);
        ld_done = 1;
        step();
        ld_done = 0;
        chk("ready_after_done", ready, 1);
        chk("ld_count_4", ld_count, 4);

        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                raddr0 = tbl[i].a0;
                raddr1 = tbl[i].a1;
                wen    = tbl[i].we;
                waddr  = tbl[i].wa;
                wdata  = tbl[i].wd;
            end else begin
                idle();
            end
            step();
            if (i > 0) begin
                chk($sformatf("vec%0d_rdata0", i - 1), rdata0, tbl[i-1].e0);
                chk($sformatf("vec%0d_rdata1", i - 1), rdata1, tbl[i-1].e1);
                chk($sformatf("vec%0d_rvalid0", i - 1), rvalid0, 1);
            end
        end

        for (int i = 0; i < 300; i++) begin
            raddr0   = AW'($urandom_range(0, 11));
            raddr1   = AW'($urandom_range(0, 11));
            wen      = 1'($urandom_range(0, 2) == 0);
            waddr    = AW'($urandom_range(0, 11));
            wdata    = DW'($urandom);
            ld_valid = 1'($urandom);
            ld_data  = DW'($urandom);
            ld_done  = 1'($urandom);
            step();
        end

        mid_reset();
        ld_done = 1;
        step();
        ld_done = 0;
        chk("reload_ld_count", ld_count, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            raddr0 = AW'(i % DEPTH);
            raddr1 = AW'((DEPTH - 1) - (i % DEPTH));
            step();
        end

        mid_reset();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1;
            ld_data  = DW'(16'hA000 + i);
            wen      = 1;
            waddr    = AW'(1);
            wdata    = 16'hFFFF;
            step();
        end
        idle();
        chk("ovf_ld_count", ld_count, 8);
        chk("ovf_flag", ld_overflow, 1);
        ld_done = 1;
        step();
        ld_done = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            raddr0 = (i < DEPTH) ? AW'(i) : '0;
            step();
            if (i > 0)
                chk($sformatf("ovf_word%0d", i - 1), rdata0,
                    DW'(16'hA000 + (i - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
